// File: rtl/pll_measure_seq.sv
// pll_measure_seq: Avalon-MM master that runs one PLL frequency-counter measurement per start pulse.
// Define PLLSEQ_ID_CHECK_EN to read and verify the slave ID before each measurement.
module pll_measure_seq #(
   parameter int unsigned SETTLE        = 8,
   parameter logic [31:0] TIMEOUT_POLLS = 32'hFFFF_FFFF,
   parameter logic [31:0] EXPECTED_ID   = 32'd1
) (
   input  logic        avalon_clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] window,
   output logic        busy,
   output logic        result_valid,
   output logic [31:0] result_count,
   output logic        result_locked,
   output logic        error_timeout,
   output logic        error_id,
   output logic [3:0]  m_address,
   output logic        m_write,
   output logic        m_read,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata
);
`ifdef PLLSEQ_ID_CHECK_EN
   localparam bit ID_EN = 1'b1;
`else
   localparam bit ID_EN = 1'b0;
`endif
   typedef enum logic [3:0] {
      IDLE, ID_RD, ID_CHK, CLR_WR, NUM_WR, GO_WR, POLL_RD, POLL_CHK,
      ABORT_WR, SETTLE_W, CNT_RD, CNT_CAP, LCK_RD, LCK_CAP, DONE
   } state_t;
   state_t state, next;
   logic [31:0] win, polls, settle_cnt;
   logic id_err;
   always_ff @(posedge avalon_clock or posedge reset)
      if (reset) begin
         state         <= IDLE;
         win           <= '0;
         polls         <= '0;
         settle_cnt    <= '0;
         result_count  <= '0;
         result_locked <= 1'b0;
         error_timeout <= 1'b0;
         id_err        <= 1'b0;
      end else begin
         state      <= next;
         settle_cnt <= (state == SETTLE_W) ? settle_cnt + 32'd1 : '0;
         if (state == IDLE && start) begin
            win           <= window;
            polls         <= '0;
            error_timeout <= 1'b0;
            id_err        <= 1'b0;
         end
         if (state == POLL_RD && polls != '1) polls <= polls + 32'd1;
         if (state == ID_CHK && m_readdata != EXPECTED_ID) id_err <= 1'b1;
         if (state == ABORT_WR) error_timeout <= 1'b1;
         if (state == CNT_CAP) result_count <= m_readdata;
         if (state == LCK_CAP) result_locked <= m_readdata[0];
      end
   always_comb begin
      next        = state;
      m_address   = '0;
      m_write     = 1'b0;
      m_read      = 1'b0;
      m_writedata = '0;
      case (state)
         IDLE:     if (start) next = ID_EN ? ID_RD : CLR_WR;
         ID_RD:    begin m_read = 1'b1; m_address = 4'd6; next = ID_CHK; end
         ID_CHK:   next = (m_readdata == EXPECTED_ID) ? CLR_WR : DONE;
         CLR_WR:   begin m_write = 1'b1; m_address = 4'd2; next = NUM_WR; end
         NUM_WR:   begin m_write = 1'b1; m_address = 4'd1; m_writedata = win; next = GO_WR; end
         GO_WR:    begin m_write = 1'b1; m_writedata = 32'd1; next = POLL_RD; end
         POLL_RD:  begin m_read = 1'b1; next = POLL_CHK; end
         POLL_CHK: next = !m_readdata[0] ? SETTLE_W : (polls < TIMEOUT_POLLS) ? POLL_RD : ABORT_WR;
         ABORT_WR: begin m_write = 1'b1; next = DONE; end
         // settle_cnt restarts at 0 on entry, so SETTLE cycles are spent here
         SETTLE_W: next = (settle_cnt == SETTLE - 1) ? CNT_RD : SETTLE_W;
         CNT_RD:   begin m_read = 1'b1; m_address = 4'd4; next = CNT_CAP; end
         CNT_CAP:  next = LCK_RD;
         LCK_RD:   begin m_read = 1'b1; m_address = 4'd5; next = LCK_CAP; end
         LCK_CAP:  next = DONE;
         DONE:     next = IDLE;
         default:  next = IDLE;
      endcase
   end
   assign busy         = state != IDLE;
   assign result_valid = state == DONE;
   assign error_id     = id_err & ID_EN;
endmodule
